// File: rtl/ecc_add_issuer.sv
// ecc_add_issuer: hands one point-add job at a time to an ECC point-add core.
// It waits a bounded number of cycles for the core's result and returns
// either that result or a timeout flag.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_Px/Py/Qx/Qy, req_valid      incoming job operands and handshake
//   req_ready                       high only while idle (decoded from state)
//   Px/Py/Qx/Qy, in_valid           operands and one-cycle start strobe to the core
//   Rx/Ry, out_valid                core result, valid only while out_valid=1
//   res_Rx/res_Ry, res_timeout      returned result and timeout flag
//   res_valid, res_ready            result handshake
//   stray_err                       sticky: out_valid seen while not waiting
module ecc_add_issuer #(
   parameter int unsigned W       = 256,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] req_Px,
   input  logic [W-1:0] req_Py,
   input  logic [W-1:0] req_Qx,
   input  logic [W-1:0] req_Qy,
   input  logic         req_valid,
   output logic         req_ready,
   output logic [W-1:0] Px,
   output logic [W-1:0] Py,
   output logic [W-1:0] Qx,
   output logic [W-1:0] Qy,
   output logic         in_valid,
   input  logic [W-1:0] Rx,
   input  logic [W-1:0] Ry,
   input  logic         out_valid,
   output logic [W-1:0] res_Rx,
   output logic [W-1:0] res_Ry,
   output logic         res_timeout,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         stray_err
);

   localparam int unsigned CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_px;
   logic [W-1:0]   r_py;
   logic [W-1:0]   r_qx;
   logic [W-1:0]   r_qy;
   logic [W-1:0]   r_res_rx;
   logic [W-1:0]   r_res_ry;
   logic           r_res_timeout;
   logic           r_res_valid;
   logic           r_in_valid;
   logic           r_stray;
   logic           w_req_fire;
   logic           w_timeout_hit;

   assign w_req_fire    = req_valid && (r_state == S_IDLE);
   assign w_timeout_hit = (r_cnt == CW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a result beats a timeout in the same cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (out_valid || w_timeout_hit) w_next = S_DONE;
         S_DONE:  if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: operands, wait counter, result capture, strobes, stray flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_px          <= '0;
         r_py          <= '0;
         r_qx          <= '0;
         r_qy          <= '0;
         r_res_rx      <= '0;
         r_res_ry      <= '0;
         r_res_timeout <= 1'b0;
         r_res_valid   <= 1'b0;
         r_in_valid    <= 1'b0;
         r_stray       <= 1'b0;
      end else begin
         // ISSUE and DONE are entered only from one place each, so the strobes
         // can be registered straight from the next state
         r_in_valid  <= (w_next == S_ISSUE);
         r_res_valid <= (w_next == S_DONE);

         if (w_req_fire) begin
            r_px <= req_Px;
            r_py <= req_Py;
            r_qx <= req_Qx;
            r_qy <= req_Qy;
         end

         case (r_state)
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (out_valid) begin
                  r_res_rx      <= Rx;
                  r_res_ry      <= Ry;
                  r_res_timeout <= 1'b0;
               end else if (w_timeout_hit) begin
                  r_res_rx      <= '0;
                  r_res_ry      <= '0;
                  r_res_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase

         if (out_valid && (r_state != S_WAIT)) r_stray <= 1'b1;
      end
   end

   assign req_ready   = (r_state == S_IDLE);
   assign Px          = r_px;
   assign Py          = r_py;
   assign Qx          = r_qx;
   assign Qy          = r_qy;
   assign in_valid    = r_in_valid;
   assign res_Rx      = r_res_rx;
   assign res_Ry      = r_res_ry;
   assign res_timeout = r_res_timeout;
   assign res_valid   = r_res_valid;
   assign stray_err   = r_stray;

endmodule

// File: tb/tb_ecc_add_issuer.sv
// Testbench for ecc_add_issuer (W=32, TIMEOUT=16). A job model predicts each
// outcome from the core delay: if the delay is within TIMEOUT, the result is
// returned; otherwise a timeout is returned.
module tb_ecc_add_issuer;

   localparam int unsigned W = 32;
   localparam int unsigned T = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] req_Px, req_Py, req_Qx, req_Qy;
   logic         req_valid;
   logic         req_ready;
   logic [W-1:0] Px, Py, Qx, Qy;
   logic         in_valid;
   logic [W-1:0] Rx, Ry;
   logic         out_valid;
   logic [W-1:0] res_Rx, res_Ry;
   logic         res_timeout;
   logic         res_valid;
   logic         res_ready;
   logic         stray_err;

   int checks   = 0;
   int failures = 0;

   ecc_add_issuer #(.W(W), .TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_Px(req_Px), .req_Py(req_Py), .req_Qx(req_Qx), .req_Qy(req_Qy),
      .req_valid(req_valid), .req_ready(req_ready),
      .Px(Px), .Py(Py), .Qx(Qx), .Qy(Qy), .in_valid(in_valid),
      .Rx(Rx), .Ry(Ry), .out_valid(out_valid),
      .res_Rx(res_Rx), .res_Ry(res_Ry), .res_timeout(res_timeout),
      .res_valid(res_valid), .res_ready(res_ready), .stray_err(stray_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete job: the core answers d cycles into WAIT (beyond T = never
   // in time), and the result is held under backpressure for 'hold' cycles.
   task automatic run_job(input string tag,
                          input logic [W-1:0] px, input logic [W-1:0] py,
                          input logic [W-1:0] qx, input logic [W-1:0] qy,
                          input logic [W-1:0] rx, input logic [W-1:0] ry,
                          input int d, input int hold);
      logic [W-1:0] e_rx, e_ry;
      logic         e_to;
      int           lat;
      int           c;
      // Model: in-time answer wins (including exactly at T), otherwise a timeout
      if (d <= int'(T)) begin
         e_rx = rx; e_ry = ry; e_to = 1'b0; lat = d + 1;
      end else begin
         e_rx = '0; e_ry = '0; e_to = 1'b1; lat = int'(T) + 1;
      end

      chk({tag, "_idle_ready"}, W'(req_ready), W'(1));
      req_Px = px; req_Py = py; req_Qx = qx; req_Qy = qy; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk({tag, "_in_valid"}, W'(in_valid), W'(1));
      chk({tag, "_issue_ready"}, W'(req_ready), W'(0));
      chk({tag, "_Px"}, Px, px);
      chk({tag, "_Qy"}, Qy, qy);

      for (c = 1; c <= 40; c++) begin
         tick();
         out_valid = 1'b0;
         Rx = $urandom;
         Ry = $urandom;
         if (res_valid) break;
         if (c == 1) chk({tag, "_in_valid_one"}, W'(in_valid), W'(0));
         if (c == d) begin
            out_valid = 1'b1; Rx = rx; Ry = ry;
         end
      end
      chk({tag, "_latency"}, W'(c), W'(lat));
      chk({tag, "_res_Rx"}, res_Rx, e_rx);
      chk({tag, "_res_Ry"}, res_Ry, e_ry);
      chk({tag, "_res_timeout"}, W'(res_timeout), W'(e_to));
      chk({tag, "_Py_held"}, Py, py);

      for (int h = 0; h < hold; h++) begin
         res_ready = 1'b0;
         req_valid = 1'b1;
         req_Px = ~px;
         tick();
         chk({tag, "_bp_ready"}, W'(req_ready), W'(0));
         chk({tag, "_bp_valid"}, W'(res_valid), W'(1));
         chk({tag, "_bp_Rx"}, res_Rx, e_rx);
         chk({tag, "_bp_to"}, W'(res_timeout), W'(e_to));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      req_valid = 1'b0;
      chk({tag, "_ret_valid"}, W'(res_valid), W'(0));
      chk({tag, "_ret_ready"}, W'(req_ready), W'(1));
      chk({tag, "_ret_Px"}, Px, px);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; res_ready = 1'b0; out_valid = 1'b0;
      req_Px = '0; req_Py = '0; req_Qx = '0; req_Qy = '0;
      Rx = '0; Ry = '0;

      // Reset state
      #2;
      chk("rst_in_valid", W'(in_valid), W'(0));
      chk("rst_res_valid", W'(res_valid), W'(0));
      chk("rst_Px", Px, '0);
      chk("rst_stray", W'(stray_err), W'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_req_ready", W'(req_ready), W'(1));

      // Directed jobs: basic, never-answers, race at T, just past T, fastest core
      run_job("basic", 1, 2, 3, 4, 5, 6, 10, 0);
      run_job("timeout", 9, 9, 9, 9, 1, 1, 1000, 0);
      run_job("race", 11, 12, 13, 14, 7, 8, int'(T), 0);
      run_job("late", 21, 22, 23, 24, 5, 5, int'(T) + 1, 0);
      run_job("fast", 31, 32, 33, 34, 35, 36, 1, 0);
      run_job("backpressure", 1, 2, 3, 4, 5, 6, 3, 20);
      chk("no_stray_yet", W'(stray_err), W'(0));

      // Stray core pulse while idle
      out_valid = 1'b1; Rx = 32'hdead; Ry = 32'hbeef;
      tick();
      out_valid = 1'b0;
      chk("stray_set", W'(stray_err), W'(1));
      chk("stray_no_result", W'(res_valid), W'(0));
      run_job("after_stray", 41, 42, 43, 44, 45, 46, 5, 1);
      chk("stray_sticky", W'(stray_err), W'(1));

      // Randomized jobs
      for (int j = 0; j < 10; j++) begin
         run_job("rand", $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
      end
      run_job("pre_rst_timeout", 5, 6, 7, 8, 1, 1, 500, 0);

      // Reset in the middle of WAIT
      req_Px = 32'h1234; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_valid", W'(in_valid), W'(0));
      chk("mid_rst_res_valid", W'(res_valid), W'(0));
      chk("mid_rst_timeout", W'(res_timeout), W'(0));
      chk("mid_rst_stray", W'(stray_err), W'(0));
      chk("mid_rst_Px", Px, '0);
      chk("mid_rst_res_Rx", res_Rx, '0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", W'(req_ready), W'(1));
      chk("post_rst_res_valid", W'(res_valid), W'(0));
      out_valid = 1'b1; Rx = 32'h77; Ry = 32'h88;
      tick();
      out_valid = 1'b0;
      chk("post_rst_stray", W'(stray_err), W'(1));
      chk("post_rst_no_result", W'(res_valid), W'(0));
      run_job("final", 2, 4, 6, 8, 10, 12, 7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ecc_add_issuer.md
ECC_ADD_ISSUER -- requirements
Module: ecc_add_issuer

Interface
REQ-001 SHALL have parameter W, default 256: operand/coordinate width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 4096: max cycles waited for core out_valid.
REQ-003 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports req_Px, req_Py, req_Qx, req_Qy input W each: job operands P=(Px,Py), Q=(Qx,Qy).
REQ-006 SHALL have port req_valid input 1 and req_ready output 1: job handshake; transfer when both high at a clock edge.
REQ-007 SHALL have ports Px, Py, Qx, Qy output W each: operands driven to the point-add core.
REQ-008 SHALL have port in_valid output 1: one-cycle start strobe to the core.
REQ-009 SHALL have ports Rx, Ry input W each and out_valid input 1: core result, valid only in the cycle out_valid=1.
REQ-010 SHALL have ports res_Rx, res_Ry output W each, res_timeout output 1: returned result and timeout flag.
REQ-011 SHALL have port res_valid output 1 and res_ready input 1: result handshake; transfer when both high at a clock edge.
REQ-012 SHALL have port stray_err output 1: sticky flag, out_valid seen outside WAIT.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; reset state IDLE.
REQ-014 SHALL drive req_ready=1 only in IDLE (combinational from state).
REQ-015 SHALL, on req transfer in IDLE, register the four operands into Px/Py/Qx/Qy and go to ISSUE.
REQ-016 SHALL drive in_valid=1 for exactly the one cycle spent in ISSUE, then go to WAIT with wait counter cleared to 0.
REQ-017 SHALL hold Px/Py/Qx/Qy stable from ISSUE until the next accepted job.
REQ-018 SHALL, in WAIT, increment the wait counter each cycle out_valid=0; counter width ceil(log2(TIMEOUT))+1, no wrap.
REQ-019 SHALL, in WAIT with out_valid=1, capture Rx/Ry into res_Rx/res_Ry, clear res_timeout, go to DONE.
REQ-020 SHALL, in WAIT with out_valid=0 and counter==TIMEOUT-1, set res_Rx=res_Ry=0, res_timeout=1, go to DONE.
REQ-021 SHALL give out_valid priority over timeout when both occur in the same cycle.
REQ-022 SHALL drive res_valid=1 exactly while in DONE; res_Rx/res_Ry/res_timeout stable while res_valid=1.
REQ-023 SHALL, in DONE with res_ready=1, return to IDLE; a new job cannot be accepted in that same cycle (req_ready=0 in DONE).
REQ-024 SHALL ignore out_valid in IDLE, ISSUE, DONE for results, and set stray_err=1 (sticky until reset).
REQ-025 SHALL have latency: job accepted at edge N -> in_valid high cycle N+1 -> earliest res_valid cycle after edge of first out_valid in WAIT; out_valid at edge M -> res_valid from M+1.
REQ-026 SHALL have throughput: at most one outstanding job; minimum 4 cycles per job when core latency is 1.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, in_valid=0, res_valid=0, res_timeout=0, stray_err=0, Px/Py/Qx/Qy/res_Rx/res_Ry=0.
REQ-028 SHALL, if reset asserts mid-job (ISSUE/WAIT/DONE), discard the job with no result; core out_valid after reset release counts as stray.

Verification
REQ-029 SHALL cover basic job: Px=1,Py=2,Qx=3,Qy=4, core returns Rx=5,Ry=6 after 10 cycles -> in_valid one cycle, res_valid with res_Rx=5,res_Ry=6,res_timeout=0.
REQ-030 SHALL cover timeout: TIMEOUT=16, core never responds -> res_valid after 16 WAIT cycles, res_Rx=res_Ry=0, res_timeout=1.
REQ-031 SHALL cover race: TIMEOUT=16, out_valid on 16th WAIT cycle with Rx=7,Ry=8 -> res_timeout=0, res_Rx=7, res_Ry=8.
REQ-032 SHALL cover backpressure: res_ready=0 for 20 cycles while req_valid=1 -> req_ready=0 throughout, res_* stable, second job accepted only after DONE->IDLE.
REQ-033 SHALL cover stray: out_valid pulse in IDLE -> stray_err=1, res_valid stays 0; following job completes normally.
REQ-034 SHALL cover reset mid-WAIT: rst_n low 1 cycle -> all outputs 0 immediately, IDLE, req_ready=1 after release.
